// File: rtl/draw_rect_multi_if.sv
// VGA pixel stream bundle: timing counters, sync/blank flags and colour.
// The producer drives through master; the consumer samples through slave.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_rect_multi.sv
// Overlays NUM_RECT solid rectangles on a VGA stream; a key press cycles
// which rectangle bounces horizontally, one step per frame.
module draw_rect_multi #(
  parameter int NUM_RECT = 4,
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int STEP     = 4,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter logic [NUM_RECT*12-1:0] RECT_COLORS =
    {12'hFF0, 12'h00F, 12'h0F0, 12'hF00}
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  key_pressed,
  vga_if.slave  rect_in,
  vga_if.master rect_out
);

  localparam int SW = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_RECT - 1);
  localparam logic [11:0] Y0    = 12'd64;
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - RECT_W);
  localparam logic [11:0] STP   = 12'(STEP);
  localparam logic [11:0] W12   = 12'(RECT_W);
  localparam logic [11:0] H12   = 12'(RECT_H);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [11:0]   x_q [NUM_RECT];
  logic [11:0]   x_d [NUM_RECT];
  logic [NUM_RECT-1:0] dir_q, dir_d;

  logic key_s1_q, key_s2_q, key_prev_q;
  logic vblnk_prev_q;
  logic key_evt, frame_tick;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q;
  logic        hblnk_q, vblnk_q;
  logic [11:0] rgb_q, rgb_d;

  logic [11:0] hc, vc;
  logic [NUM_RECT-1:0] hit, edg;
  logic active;

  assign key_evt    = key_s2_q & ~key_prev_q;
  assign frame_tick = rect_in.vblnk & ~vblnk_prev_q;

  // dir bit: 0 = moving right, 1 = moving left
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    dir_d   = dir_q;
    if (key_evt) begin
      unique case (1'b1)
        state_q == IDLE: begin
          state_d = RUN;
          sel_d   = '0;
        end
        sel_q == LAST: begin
          state_d = IDLE;
          sel_d   = '0;
        end
        default: sel_d = sel_q + 1'b1;
      endcase
    end
    if (state_q == RUN && frame_tick) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        if (sel_q == SW'(i)) begin
          if (!dir_q[i]) begin
            if (x_q[i] + STP > X_MAX) begin
              x_d[i]   = X_MAX;
              dir_d[i] = 1'b1;
            end else begin
              x_d[i] = x_q[i] + STP;
            end
          end else begin
            if (x_q[i] < STP) begin
              x_d[i]   = '0;
              dir_d[i] = 1'b0;
            end else begin
              x_d[i] = x_q[i] - STP;
            end
          end
        end
      end
    end
  end

  assign hc = {1'b0, rect_in.hcount};
  assign vc = {1'b0, rect_in.vcount};
  assign active = !(rect_in.hblnk | rect_in.vblnk)
                  && hc < 12'(H_ACTIVE)
                  && vc < 12'(V_ACTIVE);

  always_comb begin
    for (int i = 0; i < NUM_RECT; i++) begin
      hit[i] = (hc >= x_q[i]) && (hc < x_q[i] + W12)
            && (vc >= Y0) && (vc < Y0 + H12);
      edg[i] = (hc == x_q[i]) || (hc == x_q[i] + W12 - 12'd1)
            || (vc == Y0) || (vc == Y0 + H12 - 12'd1);
    end
  end

  // descending scan so the lowest index ends up on top
  always_comb begin
    rgb_d = rect_in.rgb;
    if (active) begin
      for (int i = NUM_RECT - 1; i >= 0; i--) begin
        if (hit[i]) rgb_d = RECT_COLORS[i*12 +: 12];
      end
      if (state_q == RUN && hit[sel_q] && edg[sel_q])
        rgb_d = 12'hFFF;
    end
  end

  // vblnk_prev resets high so a blank already active at release is no tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      dir_q        <= '0;
      key_s1_q     <= 1'b0;
      key_s2_q     <= 1'b0;
      key_prev_q   <= 1'b0;
      vblnk_prev_q <= 1'b1;
      for (int i = 0; i < NUM_RECT; i++)
        x_q[i] <= 12'(16 + i * (RECT_W + 16));
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      x_q          <= x_d;
      key_s1_q     <= key_pressed;
      key_s2_q     <= key_s1_q;
      key_prev_q   <= key_s2_q;
      vblnk_prev_q <= rect_in.vblnk;
      hcount_q <= rect_in.hcount;
      vcount_q <= rect_in.vcount;
      hsync_q  <= rect_in.hsync;
      vsync_q  <= rect_in.vsync;
      hblnk_q  <= rect_in.hblnk;
      vblnk_q  <= rect_in.vblnk;
      rgb_q    <= rgb_d;
    end
  end

  assign rect_out.hcount = hcount_q;
  assign rect_out.vcount = vcount_q;
  assign rect_out.hsync  = hsync_q;
  assign rect_out.vsync  = vsync_q;
  assign rect_out.hblnk  = hblnk_q;
  assign rect_out.vblnk  = vblnk_q;
  assign rect_out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_rect_multi.sv
// Directed bench for draw_rect_multi: reset, draw path, key/FSM,
// bounce motion and key/tick coincidence.
module tb_draw_rect_multi;

  logic clk;
  logic rst;
  logic key;
  int   total;
  int   bad;

  vga_if vin ();
  vga_if vout ();

  draw_rect_multi dut (
    .clk         (clk),
    .rst         (rst),
    .key_pressed (key),
    .rect_in     (vin),
    .rect_out    (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v,
                       input logic hs, input logic vs,
                       input logic hb, input logic vb,
                       input logic [11:0] c);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = c;
  endtask

  task automatic pix(input string tag, input int h, input int v,
                     input logic [11:0] bg,
                     input logic [11:0] exp);
    drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, bg);
    step();
    chk(tag, 32'(vout.rgb), 32'(exp));
  endtask

  task automatic frame();
    vin.vblnk = 1'b0;
    repeat (2) step();
    vin.vblnk = 1'b1;
    repeat (2) step();
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic press(input int hold);
    key = 1'b1;
    repeat (hold) step();
    key = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    key   = 1'b0;
    rst   = 1'b0;
    drive(300, 200, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
    step();

    // reset mid-line with busy inputs
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rgb", 32'(vout.rgb), 32'h0);
    chk("rst_hcount", 32'(vout.hcount), 32'h0);
    chk("rst_hsync", 32'(vout.hsync), 32'h0);
    chk("rst_vsync", 32'(vout.vsync), 32'h0);
    chk("rst_x0", 32'(dut.x_q[0]), 32'd16);
    chk("rst_x1", 32'(dut.x_q[1]), 32'd80);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    rst = 1'b0;
    step();

    // draw path in IDLE
    drive(16, 64, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    chk("p16_rgb", 32'(vout.rgb), 32'hF00);
    chk("p16_hsync", 32'(vout.hsync), 32'h1);
    chk("p16_vsync", 32'(vout.vsync), 32'h0);
    drive(15, 64, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    step();
    chk("p15_rgb", 32'(vout.rgb), 32'h000);
    chk("p15_hsync", 32'(vout.hsync), 32'h0);
    chk("p15_vsync", 32'(vout.vsync), 32'h1);
    chk("p15_hcount", 32'(vout.hcount), 32'd15);
    chk("p15_vcount", 32'(vout.vcount), 32'd64);
    pix("idle_r1", 100, 100, 12'h123, 12'h0F0);
    pix("idle_r3", 230, 127, 12'h123, 12'hFF0);
    pix("idle_below", 100, 128, 12'h123, 12'h123);
    pix("idle_r0_last", 63, 64, 12'h123, 12'hF00);
    pix("idle_gap", 64, 64, 12'h123, 12'h123);
    drive(20, 70, 1'b0, 1'b0, 1'b1, 1'b0, 12'h456);
    step();
    chk("hblank_pass", 32'(vout.rgb), 32'h456);

    // start motion, three frames
    press(1);
    chk("run_state", 32'(dut.state_q), 32'd1);
    chk("run_sel", 32'(dut.sel_q), 32'd0);
    repeat (3) frame();
    chk("t3_x0", 32'(dut.x_q[0]), 32'd28);
    chk("t3_x1", 32'(dut.x_q[1]), 32'd80);
    chk("t3_x2", 32'(dut.x_q[2]), 32'd144);
    chk("t3_x3", 32'(dut.x_q[3]), 32'd208);
    pix("border_28", 28, 64, 12'h123, 12'hFFF);
    pix("inner_40", 40, 80, 12'h123, 12'hF00);
    pix("left_27", 27, 80, 12'h123, 12'h123);
    pix("border_r75", 75, 80, 12'h123, 12'hFFF);

    // overlap with rectangle 1
    repeat (13) frame();
    chk("ovl_x0", 32'(dut.x_q[0]), 32'd80);
    pix("ovl_pix", 100, 100, 12'h123, 12'hF00);

    // right edge bounce
    repeat (168) frame();
    chk("edge_x0", 32'(dut.x_q[0]), 32'd752);
    chk("edge_dir0", 32'(dut.dir_q[0]), 32'd0);
    frame();
    chk("bnc_x0", 32'(dut.x_q[0]), 32'd752);
    chk("bnc_dir0", 32'(dut.dir_q[0]), 32'd1);
    frame();
    chk("left_x0", 32'(dut.x_q[0]), 32'd748);

    // long hold counts once
    press(1000);
    chk("hold_sel", 32'(dut.sel_q), 32'd1);
    frame();
    chk("s1_x1", 32'(dut.x_q[1]), 32'd84);
    chk("s1_x0", 32'(dut.x_q[0]), 32'd748);
    press(2);
    press(2);
    chk("sel3", 32'(dut.sel_q), 32'd3);
    press(2);
    chk("wrap_state", 32'(dut.state_q), 32'd0);
    chk("wrap_sel", 32'(dut.sel_q), 32'd0);
    repeat (2) frame();
    chk("idle_x0", 32'(dut.x_q[0]), 32'd748);
    chk("idle_x1", 32'(dut.x_q[1]), 32'd84);
    chk("idle_x3", 32'(dut.x_q[3]), 32'd208);

    // reset during vblank: no tick at release
    drive(100, 610, 1'b1, 1'b1, 1'b0, 1'b1, 12'h777);
    rst = 1'b1;
    step();
    chk("rst2_rgb", 32'(vout.rgb), 32'h0);
    chk("rst2_vblnk", 32'(vout.vblnk), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    press(1);
    repeat (3) step();
    chk("rst2_x0", 32'(dut.x_q[0]), 32'd16);
    chk("rst2_state", 32'(dut.state_q), 32'd1);
    vin.vblnk = 1'b0;
    repeat (2) step();

    // key event and frame tick on the same clock
    key = 1'b1;
    repeat (2) step();
    vin.vblnk = 1'b1;
    step();
    key = 1'b0;
    chk("co_x0", 32'(dut.x_q[0]), 32'd20);
    chk("co_x1", 32'(dut.x_q[1]), 32'd80);
    chk("co_sel", 32'(dut.sel_q), 32'd1);
    step();
    vin.vblnk = 1'b0;
    repeat (3) step();
    frame();
    chk("co_next_x1", 32'(dut.x_q[1]), 32'd84);
    chk("co_next_x0", 32'(dut.x_q[0]), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
